// File: rtl/hall98_pkg.sv
// Shared types and constants for the hall98 core.
// Holds the LSU FSM state encoding, op codes and default widths.
package hall98_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lsu_state_e;

    localparam logic OP_LDR = 1'b0;
    localparam logic OP_STR = 1'b1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 3;

endpackage

// File: rtl/hall98_lsu_if.sv
// Request/response handshake bundle between execute and the LSU.
// master = issuing core side, slave = the load/store unit.
interface hall98_lsu_if
    import hall98_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 8,
    parameter int REG_W  = DEF_REG_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [REG_W-1:0]  req_rd;

    logic              resp_valid;
    logic              resp_ready;
    logic              resp_store;
    logic [REG_W-1:0]  resp_rd;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_fault;

    modport master (
        output req_valid, req_store, req_addr,
        output req_wdata, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_store,
        input  resp_rd, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_store, req_addr,
        input  req_wdata, req_rd, resp_ready,
        output req_ready, resp_valid, resp_store,
        output resp_rd, resp_rdata, resp_fault
    );

endinterface

// File: rtl/hall98_lsu_mem.sv
// Single-port synchronous word RAM for the hall98 LSU.
// Read data is registered and only changes on an enabled read.
module hall98_lsu_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/hall98_lsu.sv
// hall98 load/store unit: one outstanding LDR/STR with a programmable wait.
// Define HALL98_LSU_BOUNDS_EN to flag out-of-range accesses on resp_fault.
module hall98_lsu
    import hall98_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int REG_W       = DEF_REG_W,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        iclock,
    input  logic        irst_n,
    hall98_lsu_if.slave bus,
    output logic        busy
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        RSEL_ZERO,
        RSEL_MEM,
        RSEL_WDATA
    } rsel_e;

    lsu_state_e        state, state_nx;
    logic [3:0]        cnt;
    logic              st_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [REG_W-1:0]  rd_q;
    logic              fault_q;
    rsel_e             rsel_q;

    logic              accept;
    logic              commit;
    logic              in_range;
    logic              flt;
    logic [DATA_W-1:0] mem_rdata;

    assign in_range = {1'b0, addr_q} < DEPTH_L;

`ifdef HALL98_LSU_BOUNDS_EN
    assign flt = !in_range;
`else
    assign flt = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    commit   = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge iclock) begin
        if (!irst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            st_q    <= OP_LDR;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            fault_q <= 1'b0;
            rsel_q  <= RSEL_ZERO;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt     <= WAIT_L;
                st_q    <= bus.req_store;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                rd_q    <= bus.req_rd;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                fault_q <= flt;
                if (flt) begin
                    rsel_q <= RSEL_ZERO;
                end else if (st_q == OP_STR) begin
                    rsel_q <= RSEL_WDATA;
                end else if (in_range) begin
                    rsel_q <= RSEL_MEM;
                end else begin
                    rsel_q <= RSEL_ZERO;
                end
            end
        end
    end

    // Reset wins over a commit landing on the same edge.
    hall98_lsu_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (ADDR_W)
    ) u_mem (
        .clk   (iclock),
        .en    (commit && in_range && irst_n),
        .we    (st_q == OP_STR),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        bus.resp_rdata = '0;
        unique case (rsel_q)
            RSEL_MEM:   bus.resp_rdata = mem_rdata;
            RSEL_WDATA: bus.resp_rdata = wdata_q;
            default:    bus.resp_rdata = '0;
        endcase
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_store = st_q;
    assign bus.resp_rd    = rd_q;
    assign bus.resp_fault = fault_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_hall98_lsu.sv
// Randomized self-checking bench for hall98_lsu against an array model.
// Two instances: WAIT_CYCLES=0/DEPTH=256 and WAIT_CYCLES=3/DEPTH=200.
module tb_hall98_lsu;
    import hall98_pkg::*;

`ifdef HALL98_LSU_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic busy0, busy1;

    hall98_lsu_if b0 ();
    hall98_lsu_if b1 ();

    hall98_lsu #(
        .DEPTH       (256),
        .WAIT_CYCLES (0)
    ) u0 (
        .iclock (clk),
        .irst_n (rst_n),
        .bus    (b0),
        .busy   (busy0)
    );

    hall98_lsu #(
        .DEPTH       (200),
        .WAIT_CYCLES (3)
    ) u1 (
        .iclock (clk),
        .irst_n (rst_n),
        .bus    (b1),
        .busy   (busy1)
    );

    virtual hall98_lsu_if vif;

    int cur;
    int wt;
    int dp;
    int n_run;
    int n_fail;

    logic [31:0] ref_m [2][256];
    bit          ref_v [2][256];

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d got=%0h exp=%0h",
                     tag, cur, got, exp);
        end
    endtask

    function automatic logic bsy();
        return (cur == 0) ? busy0 : busy1;
    endfunction

    task automatic use_dut(input int d);
        cur = d;
        if (d == 0) begin
            vif = b0;
            wt  = 0;
            dp  = 256;
        end else begin
            vif = b1;
            wt  = 3;
            dp  = 200;
        end
    endtask

    task automatic send(input bit st, input logic [7:0] a,
                        input logic [31:0] wd,
                        input logic [2:0] rd);
        vif.req_valid = 1'b1;
        vif.req_store = st;
        vif.req_addr  = a;
        vif.req_wdata = wd;
        vif.req_rd    = rd;
        check("req_ready_idle", vif.req_ready, 1);
        @(posedge clk);
        #1;
        vif.req_valid = 1'b0;
    endtask

    task automatic await_resp();
        int lat = 0;
        while (!vif.resp_valid && lat < 40) begin
            check("busy_wait", bsy(), 1);
            check("req_ready_wait", vif.req_ready, 0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, wt + 1);
    endtask

    task automatic expect_resp(input bit st, input logic [7:0] a,
                               input logic [31:0] wd,
                               input logic [2:0] rd);
        bit          inr;
        bit          flt;
        logic [31:0] exp_d;
        inr = (int'(a) < dp);
        flt = BOUNDS && !inr;
        if (flt) exp_d = 32'h0;
        else if (st) exp_d = wd;
        else if (inr) exp_d = ref_m[cur][a];
        else exp_d = 32'h0;
        check("resp_valid", vif.resp_valid, 1);
        check("resp_store", vif.resp_store, st);
        check("resp_rd", vif.resp_rd, rd);
        check("resp_rdata", vif.resp_rdata, exp_d);
        check("resp_fault", vif.resp_fault, flt);
        if (st && inr) begin
            ref_m[cur][a] = wd;
            ref_v[cur][a] = 1'b1;
        end
    endtask

    task automatic release_resp();
        vif.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resp_valid_drop", vif.resp_valid, 0);
        check("req_ready_back", vif.req_ready, 1);
        check("busy_idle", bsy(), 0);
        vif.resp_ready = 1'b0;
    endtask

    task automatic xact(input bit st, input logic [7:0] a,
                        input logic [31:0] wd,
                        input logic [2:0] rd, input int hold);
        send(st, a, wd, rd);
        if (hold == 0) vif.resp_ready = 1'($urandom_range(0, 1));
        await_resp();
        if (hold > 0) begin
            expect_resp(st, a, wd, rd);
            repeat (hold) begin
                @(posedge clk);
                #1;
                check("hold_ready", vif.req_ready, 0);
            end
        end
        expect_resp(st, a, wd, rd);
        release_resp();
    endtask

    task automatic rand_run(input int d, input int n);
        bit          st;
        logic [7:0]  a;
        use_dut(d);
        for (int i = 0; i < n; i++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
            else a = 8'($urandom_range(0, 15));
            if (!st && int'(a) < dp && !ref_v[cur][a]) st = 1'b1;
            xact(st, a, $urandom, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 2));
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            use_dut(k);
            vif.req_valid  = 1'b0;
            vif.req_store  = 1'b0;
            vif.req_addr   = '0;
            vif.req_wdata  = '0;
            vif.req_rd     = '0;
            vif.resp_ready = 1'b0;
        end
        use_dut(0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", vif.req_ready, 1);
        check("rst_resp_valid", vif.resp_valid, 0);
        check("rst_busy", bsy(), 0);
        check("rst_rdata", vif.resp_rdata, 0);
        check("rst_fault", vif.resp_fault, 0);
        check("rst_rd", vif.resp_rd, 0);
        check("rst_store", vif.resp_store, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xact(1'b1, 8'd0, 32'h0000_000F, 3'd1, 0);
        xact(1'b0, 8'd0, 32'h0, 3'd2, 0);

        send(1'b0, 8'd0, 32'h0, 3'd3);
        await_resp();
        vif.req_valid = 1'b1;
        vif.req_store = 1'b1;
        vif.req_addr  = 8'd9;
        vif.req_wdata = 32'h99;
        vif.req_rd    = 3'd5;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_req_ready", vif.req_ready, 0);
            expect_resp(1'b0, 8'd0, 32'h0, 3'd3);
        end
        vif.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_rise", vif.req_ready, 1);
        check("bp_valid_fall", vif.resp_valid, 0);
        vif.resp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("bp_accepted", bsy(), 1);
        vif.req_valid = 1'b0;
        await_resp();
        expect_resp(1'b1, 8'd9, 32'h99, 3'd5);
        release_resp();

        use_dut(1);
        xact(1'b1, 8'd5, 32'h1234_5678, 3'd1, 0);
        xact(1'b0, 8'd5, 32'h0, 3'd4, 0);
        xact(1'b0, 8'd250, 32'h0, 3'd3, 0);
        xact(1'b1, 8'd250, 32'hDEAD_BEEF, 3'd3, 0);
        xact(1'b0, 8'd250, 32'h0, 3'd3, 0);

        xact(1'b1, 8'd7, 32'h55, 3'd1, 0);
        send(1'b1, 8'd7, 32'hAA, 3'd2);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_valid", vif.resp_valid, 0);
        check("mid_rst_busy", bsy(), 0);
        check("mid_rst_ready", vif.req_ready, 1);
        check("mid_rst_rdata", vif.resp_rdata, 0);
        xact(1'b0, 8'd7, 32'h0, 3'd3, 0);

        rand_run(0, 40);
        rand_run(1, 40);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
